seq_detect_ctrl: RTL and testbench

Run-time controller for a Mealy serial-pattern detector.
- Holds a programmable pattern configuration: pattern, length, overlap mode and target match count.
- Arms and disarms detection with start/abort, counts matches, and raises a sticky done flag when the target is reached.
- Sits between a serial bit source and the control software/FSM that schedules detection runs.

---
 rtl/seq_det_pkg.sv | 16 +
 rtl/seq_match_core.sv | 62 ++++++
 rtl/seq_detect_ctrl.sv | 127 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial-pattern detector controller.
package seq_det_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [7:0]  DEF_PATTERN = 8'b0000_1011;
  localparam int unsigned DEF_LEN     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/seq_match_core.sv
// Bit history, fill tracking and length-masked comparison for the pattern detector.
// The match output is combinational so a hit is flagged in the cycle of the final bit.
module seq_match_core #(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample,
  input  logic             x,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             match
);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] word, mask;
  logic [LEN_W:0]   fill_p1;

  assign word    = {hist_q, x};
  assign fill_p1 = {1'b0, fill_q} + (LEN_W+1)'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(PAT_W); i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  // fill >= len-1 means enough history exists to complete a pattern with x.
  assign match = sample && (fill_p1 >= {1'b0, len}) && (((word ^ pattern) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (sample) begin
      hist_d = word[PAT_W-2:0];
      if (match && !overlap) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(PAT_W)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time controller for a Mealy serial-pattern detector: configuration, run FSM,
// match counting and sticky completion flag.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             x,
  input  logic             x_valid,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d, len_clamped;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_p1;
  logic             cfg_load, start_go, sample, match, hit_target;

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign cfg_ready   = (state_q != StRun);
  assign match_count = cnt_q;
  assign z           = match;

  assign cfg_load   = cfg_valid && cfg_ready;
  assign start_go   = start && (state_q != StRun);
  assign sample     = busy && x_valid && !abort;
  assign cnt_p1     = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign hit_target = (tgt_q != '0) && (cnt_p1 == {1'b0, tgt_q});

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_W'(PAT_W)) begin
      len_clamped = LEN_W'(PAT_W);
    end
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;

    if (cfg_load) begin
      pat_d = cfg_pattern;
      len_d = len_clamped;
      ovl_d = cfg_overlap;
      tgt_d = cfg_target;
      if (state_q == StDone) state_d = StIdle;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        // abort wins over a coincident match; match is already gated by abort.
        if (abort) begin
          state_d = StIdle;
        end else if (match) begin
          if (!(&cnt_q)) cnt_d = cnt_p1[CNT_W-1:0];
          if (hit_target) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pat_q   <= PAT_W'(DEF_PATTERN);
      len_q   <= LEN_W'(DEF_LEN);
      ovl_q   <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_go),
    .sample  (sample),
    .x       (x),
    .overlap (ovl_q),
    .pattern (pat_q),
    .len     (len_q),
    .match   (match)
  );

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid, cfg_ready;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic       start, abort, x, x_valid;
  logic       z, busy, done;
  logic [7:0] match_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the bits seen since the last history discard, kept as a queue.
  bit         m_busy, m_done;
  int         m_cnt;
  bit         m_q[$];
  logic [7:0] m_pat;
  int         m_len, m_tgt;
  bit         m_ovl;

  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .x           (x),
    .x_valid     (x_valid),
    .z           (z),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_cnt = 0; m_q.delete();
    m_pat = 8'b0000_1011; m_len = 4; m_ovl = 0; m_tgt = 0;
  endtask

  // The last m_len bits of the stream (x newest) must read out pattern[len-1:0].
  function automatic bit model_z();
    bit b;
    if (!m_busy || !x_valid || abort) return 0;
    if (m_q.size() + 1 < m_len) return 0;
    for (int i = 0; i < m_len; i++) begin
      b = (i == 0) ? x : m_q[m_q.size() - i];
      if (b != m_pat[i]) return 0;
    end
    return 1;
  endfunction

  task automatic model_edge();
    bit mz;
    int l;
    mz = model_z();
    if (m_busy) begin
      if (abort) begin
        m_busy = 0;
      end else if (x_valid) begin
        m_q.push_back(x);
        if (m_q.size() > 8) void'(m_q.pop_front());
        if (mz) begin
          if (m_tgt != 0 && m_cnt + 1 == m_tgt) begin
            m_busy = 0; m_done = 1;
          end
          if (m_cnt < 255) m_cnt++;
          if (!m_ovl) m_q.delete();
        end
      end
    end else begin
      if (cfg_valid) begin
        l = int'(cfg_len);
        if (l == 0) l = 1;
        if (l > 8) l = 8;
        m_pat = cfg_pattern; m_len = l; m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
        m_done = 0;
      end
      if (start) begin
        m_busy = 1; m_done = 0; m_cnt = 0; m_q.delete();
      end
    end
  endtask

  task automatic cyc(input bit st, input bit ab, input bit cv, input bit xv, input bit xb);
    @(negedge clk);
    start = st; abort = ab; cfg_valid = cv; x_valid = xv; x = xb;
    #1;
  endtask

  task automatic clk_edge();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input bit o,
                          input logic [7:0] t);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
    cyc(0, 0, 1, 0, 0);
    clk_edge();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(0, 0, 0, 1, 1);
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL reset_z got %b want 0", z); end
    n_tests++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", match_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic run_stream(input string name, input bit bits[], input int hits[$]);
    bit exp;
    cyc(1, 0, 0, 0, 0);
    clk_edge();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_start_busy got %b want 1", name, busy); end
    foreach (bits[i]) begin
      cyc(0, 0, 0, 1, bits[i]);
      exp = 0;
      foreach (hits[k]) if (hits[k] == i) exp = 1;
      n_tests++; if (z !== exp) begin n_fail++; $display("FAIL %s_z[%0d] got %b want %b", name, i, z, exp); end
      clk_edge();
    end
  endtask

  task automatic test_nonoverlap();
    bit s[] = '{0,0,1,0,1,1,0,1,1,0,0,1,0,1,1,0};
    run_stream("nonovl", s, '{5, 14});
    n_tests++; if (match_count !== 8'd2) begin n_fail++; $display("FAIL nonovl_count got %0d want 2", match_count); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nonovl_busy got %b want 1", busy); end
    cyc(0, 1, 0, 0, 0);
    clk_edge();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nonovl_abort_busy got %b want 0", busy); end
  endtask

  task automatic test_overlap();
    bit s[] = '{0,0,1,0,1,1,0,1,1,0,0,1,0,1,1,0};
    load_cfg(8'b1011, 4'd4, 1'b1, 8'd0);
    run_stream("ovl", s, '{5, 8, 14});
    n_tests++; if (match_count !== 8'd3) begin n_fail++; $display("FAIL ovl_count got %0d want 3", match_count); end
    cyc(0, 1, 0, 0, 0);
    clk_edge();
  endtask

  task automatic test_target();
    bit s[] = '{1,0,1,1,0,1,1,0,1,1};
    load_cfg(8'b1011, 4'd4, 1'b1, 8'd2);
    run_stream("tgt", s, '{3, 6});
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tgt_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL tgt_done got %b want 1", done); end
    n_tests++; if (match_count !== 8'd2) begin n_fail++; $display("FAIL tgt_count got %0d want 2", match_count); end
    cyc(0, 1, 0, 1, 1);
    clk_edge();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL tgt_abort_in_done got %b want 1", done); end
    load_cfg(8'b1011, 4'd4, 1'b0, 8'd0);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL tgt_cfg_clears_done got %b want 0", done); end
    n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL tgt_cfg_ready got %b want 1", cfg_ready); end
  endtask

  task automatic test_abort();
    bit s[] = '{1,0,1,1,1,0,1};
    run_stream("abort", s, '{3});
    cyc(0, 1, 0, 1, 1);
    n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL abort_z got %b want 0", z); end
    clk_edge();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_tests++; if (match_count !== 8'd1) begin n_fail++; $display("FAIL abort_count got %0d want 1", match_count); end
    cyc(1, 0, 0, 0, 0);
    clk_edge();
    n_tests++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL abort_restart_count got %0d want 0", match_count); end
    cyc(0, 1, 0, 0, 0);
    clk_edge();
  endtask

  task automatic test_cfg_in_run();
    bit s[] = '{1,0,1,0,1};
    bit exp;
    load_cfg(8'b101, 4'd3, 1'b0, 8'd0);
    cyc(1, 0, 0, 0, 0);
    clk_edge();
    cfg_pattern = 8'hff; cfg_len = 4'd4;
    foreach (s[i]) begin
      cyc(0, 0, (i == 0), 1, s[i]);
      if (i == 0) begin
        n_tests++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL run_cfg_ready got %b want 0", cfg_ready); end
      end
      exp = (i == 2);
      n_tests++; if (z !== exp) begin n_fail++; $display("FAIL run_cfg_z[%0d] got %b want %b", i, z, exp); end
      clk_edge();
    end
    n_tests++; if (match_count !== 8'd1) begin n_fail++; $display("FAIL run_cfg_count got %0d want 1", match_count); end
  endtask

  task automatic test_async_reset();
    bit s[] = '{1,0,1,1};
    bit exp;
    cyc(0, 0, 0, 1, 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_tests++; if (match_count !== 8'd0) begin n_fail++; $display("FAIL areset_count got %0d want 0", match_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL areset_done got %b want 0", done); end
    n_tests++; if (z !== 1'b0) begin n_fail++; $display("FAIL areset_z got %b want 0", z); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    cyc(1, 0, 0, 0, 0);
    clk_edge();
    foreach (s[i]) begin
      cyc(0, 0, 0, 1, s[i]);
      exp = (i == 3);
      n_tests++; if (z !== exp) begin n_fail++; $display("FAIL areset_default_z[%0d] got %b want %b", i, z, exp); end
      clk_edge();
    end
    cyc(0, 1, 0, 0, 0);
    clk_edge();
  endtask

  task automatic test_random();
    bit ez;
    for (int n = 0; n < 1500; n++) begin
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom_range(0, 15));
      cfg_overlap = 1'($urandom);
      cfg_target  = 8'($urandom_range(0, 3));
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));
      ez = model_z();
      n_tests++; if (z !== ez) begin n_fail++; $display("FAIL rnd_z[%0d] got %b want %b", n, z, ez); end
      n_tests++; if (cfg_ready !== !m_busy) begin n_fail++; $display("FAIL rnd_cfg_ready[%0d] got %b want %b", n, cfg_ready, !m_busy); end
      clk_edge();
      n_tests++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy[%0d] got %b want %b", n, busy, m_busy); end
      n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL rnd_done[%0d] got %b want %b", n, done, m_done); end
      n_tests++; if (int'(match_count) != m_cnt) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, match_count, m_cnt); end
    end
  endtask

  initial begin
    reset = 1'b0;
    cfg_valid = 0; cfg_pattern = 8'b1011; cfg_len = 4'd4; cfg_overlap = 0; cfg_target = 0;
    start = 0; abort = 0; x = 0; x_valid = 0;
    model_reset();
    test_reset();
    test_nonoverlap();
    test_overlap();
    test_target();
    test_abort();
    test_cfg_in_run();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
